// File: rtl/audio_pkg.sv
// Shared types and constants for the codec audio receive path.
package audio_pkg;

    localparam int AUDIO_DATA_W = 16;

    // Receiver framing state: hunting for a frame start, inside the left slot, inside the right slot.
    typedef enum logic [1:0] {
        SEEK  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } rx_state_t;

endpackage

// File: rtl/audio_adc_rx_sync_edge.sv
// Multi-stage synchroniser for asynchronous codec pins. The edge input also
// produces a one-cycle rise strobe; the data inputs travel through the same
// flop stages so they stay cycle-aligned with the strobe.
module sync_edge #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         edge_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         rise_o
);

    // Bit 0 of each stage carries the edge input, bits W:1 carry the data inputs.
    logic [STAGES-1:0][W:0] sync_q;
    logic                   edge_prev_q;

    // Shift all inputs through the synchroniser chain and remember the last synced edge level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q      <= '0;
            edge_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[STAGES-2:0], {data_i, edge_i}};
            edge_prev_q <= sync_q[STAGES-1][0];
        end
    end

    assign data_o = sync_q[STAGES-1][W:1];
    assign rise_o = sync_q[STAGES-1][0] & ~edge_prev_q;

endmodule

// File: rtl/audio_adc_rx.sv
// Left-justified codec ADC receiver. Oversamples BCLK/LRCK/DAT in the system
// clock domain, frames left/right slots and delivers signed stereo pairs through
// a one-pair holding register.
// Handshake: a pair transfers on any clk_50mhz edge where sample_valid && sample_ready;
// sample_valid stays high and left_out/right_out stay stable until that transfer.
module audio_adc_rx
    import audio_pkg::*;
#(
    parameter int DATA_W      = AUDIO_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk_50mhz,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     aud_bclk,
    input  logic                     aud_adclrck,
    input  logic                     aud_adcdat,
    output logic signed [DATA_W-1:0] left_out,
    output logic signed [DATA_W-1:0] right_out,
    output logic                     sample_valid,
    input  logic                     sample_ready,
    input  logic                     clear_flags,
    output logic                     overrun,
    output logic                     frame_err,
    output rx_state_t                dbg_state
);

    localparam int                CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DATA_W);

    logic              bclk_rise;
    logic              lrck_s;
    logic              dat_s;

    logic              lrck_prev_q;
    logic [DATA_W-1:0] sh_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] left_sh_q;
    logic [DATA_W-1:0] left_q;
    logic [DATA_W-1:0] right_q;
    logic              valid_q;
    logic              overrun_q;
    logic              frame_err_q;

    rx_state_t         state_q;
    rx_state_t         state_d;

    logic              boundary;
    logic              slot_full;
    logic              shift_en;
    logic              word_done;
    logic [DATA_W-1:0] sh_next;
    logic [CNT_W-1:0]  cnt_next;
    logic              latch_left;
    logic              commit;
    logic              err_set;
    logic              overrun_set;

    sync_edge #(
        .W      (2),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_50mhz),
        .rst_ni (reset_n),
        .edge_i (aud_bclk),
        .data_i ({aud_adcdat, aud_adclrck}),
        .data_o ({dat_s, lrck_s}),
        .rise_o (bclk_rise)
    );

    assign boundary  = lrck_s ^ lrck_prev_q;
    assign slot_full = (cnt_q == FULL);
    assign shift_en  = boundary || (cnt_q < FULL);
    assign word_done = shift_en && (cnt_next == FULL);

    // Next shift-register/counter value: a slot boundary restarts the word with the captured MSB.
    always_comb begin
        sh_next  = {sh_q[DATA_W-2:0], dat_s};
        cnt_next = cnt_q + CNT_W'(1);
        if (boundary) begin
            sh_next  = {{(DATA_W-1){1'b0}}, dat_s};
            cnt_next = CNT_W'(1);
        end
    end

    // Capture serial bits on each bit-clock rise; the counter saturates once a word is full.
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            lrck_prev_q <= 1'b0;
            sh_q        <= '0;
            cnt_q       <= '0;
            left_sh_q   <= '0;
        end else if (bclk_rise) begin
            lrck_prev_q <= lrck_s;
            if (shift_en) begin
                sh_q  <= sh_next;
                cnt_q <= cnt_next;
            end
            if (latch_left) begin
                left_sh_q <= sh_next;
            end
        end
    end

    // Framing state register.
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SEEK;
        end else begin
            state_q <= state_d;
        end
    end

    // Framing next state: advance only on bit-clock rises, fall back to SEEK when disabled.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = SEEK;
        end else if (bclk_rise) begin
            case (state_q)
                SEEK:    if (boundary && lrck_s) state_d = LEFT;
                LEFT:    if (boundary) state_d = slot_full ? RIGHT : SEEK;
                RIGHT:   if (boundary) state_d = LEFT;
                default: state_d = SEEK;
            endcase
        end
    end

    // Framing outputs: left-word latch, pair commit and short-slot error strobes.
    always_comb begin
        latch_left = 1'b0;
        commit     = 1'b0;
        err_set    = 1'b0;
        if (enable && bclk_rise) begin
            case (state_q)
                LEFT: begin
                    if (boundary && !slot_full) err_set = 1'b1;
                    if (!boundary && word_done) latch_left = 1'b1;
                end
                RIGHT: begin
                    if (boundary && !slot_full) err_set = 1'b1;
                    if (!boundary && word_done) commit = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign overrun_set = commit && valid_q && !sample_ready;

    // Holding register and sticky flags; a new pair is dropped only when the held one is stuck.
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (commit && (!valid_q || sample_ready)) begin
                left_q  <= left_sh_q;
                right_q <= sh_next;
                valid_q <= 1'b1;
            end else if (valid_q && sample_ready) begin
                valid_q <= 1'b0;
            end
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (clear_flags) begin
                overrun_q <= 1'b0;
            end
            if (err_set) begin
                frame_err_q <= 1'b1;
            end else if (clear_flags) begin
                frame_err_q <= 1'b0;
            end
        end
    end

    assign left_out     = left_q;
    assign right_out    = right_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign frame_err    = frame_err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_audio_adc_rx.sv
// Bench for audio_adc_rx: drives a left-justified codec stream at 16 clk/bit
// and checks delivered pairs and flags against a frame-level model.
module tb_audio_adc_rx;
    import audio_pkg::*;

    localparam int DATA_W      = 16;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;

    logic clk = 1'b0;
    logic reset_n;
    logic enable;
    logic aud_bclk;
    logic aud_adclrck;
    logic aud_adcdat;
    logic signed [DATA_W-1:0] left_out;
    logic signed [DATA_W-1:0] right_out;
    logic sample_valid;
    logic sample_ready;
    logic clear_flags;
    logic overrun;
    logic frame_err;
    rx_state_t dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    logic        b2b_valid;
    logic [15:0] b2b_left;
    logic        b2b_overrun;

    audio_adc_rx #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_50mhz    (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .aud_bclk     (aud_bclk),
        .aud_adclrck  (aud_adclrck),
        .aud_adcdat   (aud_adcdat),
        .left_out     (left_out),
        .right_out    (right_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .clear_flags  (clear_flags),
        .overrun      (overrun),
        .frame_err    (frame_err),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #10 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- accepted-pair monitor ----------------
    always @(negedge clk) begin
        if (reset_n === 1'b1 && sample_valid === 1'b1 && sample_ready === 1'b1)
            got_q.push_back({left_out, right_out});
    end

    // ---------------- driver tasks ----------------
    task automatic bit_low(input logic lr, input logic d);
        aud_adclrck = lr;
        aud_adcdat  = d;
        aud_bclk    = 1'b0;
        tick(HALF);
    endtask

    task automatic bit_high();
        aud_bclk = 1'b1;
        tick(HALF);
    endtask

    // Sends nbits MSB-first from word[31:...]. At bit rdy_bit the ready input is raised
    // exactly in the cycle where that bit's commit is expected, and the state right
    // after that commit is recorded.
    task automatic send_slot(input logic lr, input logic [31:0] word, input int nbits, input int rdy_bit);
        for (int i = 0; i < nbits; i++) begin
            bit_low(lr, word[31-i]);
            if (i == rdy_bit) begin
                aud_bclk = 1'b1;
                tick(SYNC_STAGES);
                sample_ready = 1'b1;
                tick(1);
                b2b_valid   = sample_valid;
                b2b_left    = left_out;
                b2b_overrun = overrun;
                tick(HALF - SYNC_STAGES - 1);
            end else begin
                bit_high();
            end
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_slot(1'b1, {l, 16'h0000}, 16, -1);
        send_slot(1'b0, {r, 16'h0000}, 16, -1);
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; aud_bclk = 1'b0; aud_adclrck = 1'b0;
        aud_adcdat = 1'b0; sample_ready = 1'b0; clear_flags = 1'b0;
        tick(4);
        tests_run++; if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b exp 0", sample_valid); end
        tests_run++; if (left_out !== 16'h0) begin tests_failed++; $display("FAIL reset_left: got %h exp 0000", left_out); end
        tests_run++; if (right_out !== 16'h0) begin tests_failed++; $display("FAIL reset_right: got %h exp 0000", right_out); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b exp 0", overrun); end
        tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %b exp 0", frame_err); end
        tests_run++; if (dbg_state !== SEEK) begin tests_failed++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, SEEK); end
        reset_n = 1'b1;
        tick(4);
    endtask

    task automatic test_nominal();
        sample_ready = 1'b1;
        got_q.delete(); exp_q.delete();
        exp_q.push_back(32'h1234_BEEF);
        send_frame(16'h1234, 16'hBEEF);
        tick(4);
        tests_run++; if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL nominal_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL nominal_pair%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        tests_run++; if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL nominal_valid_drop: got %b exp 0", sample_valid); end
        tests_run++; if ({overrun, frame_err} !== 2'b00) begin tests_failed++; $display("FAIL nominal_flags: got %b exp 00", {overrun, frame_err}); end
    endtask

    task automatic test_backpressure();
        sample_ready = 1'b0;
        got_q.delete();
        send_frame(16'h0001, 16'h0002);
        tick(2);
        tests_run++; if (sample_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid_a: got %b exp 1", sample_valid); end
        tests_run++; if ({left_out, right_out} !== 32'h0001_0002) begin tests_failed++; $display("FAIL bp_pair_a: got %h exp 00010002", {left_out, right_out}); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL bp_overrun_early: got %b exp 0", overrun); end
        send_frame(16'h0003, 16'h0004);
        tick(2);
        tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL bp_overrun: got %b exp 1", overrun); end
        tests_run++; if ({left_out, right_out} !== 32'h0001_0002) begin tests_failed++; $display("FAIL bp_held: got %h exp 00010002", {left_out, right_out}); end
        sample_ready = 1'b1;
        tick(1);
        tests_run++; if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_accept_valid: got %b exp 0", sample_valid); end
        tests_run++; if (got_q.size() != 1) begin tests_failed++; $display("FAIL bp_accept_count: got %0d exp 1", got_q.size()); end
        else begin
            tests_run++; if (got_q[0] !== 32'h0001_0002) begin tests_failed++; $display("FAIL bp_accept_pair: got %h exp 00010002", got_q[0]); end
        end
        pulse_clear();
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL bp_clear: got %b exp 0", overrun); end
    endtask

    task automatic test_short_left();
        sample_ready = 1'b1;
        got_q.delete();
        send_slot(1'b1, 32'h5A5A_0000, 10, -1);
        send_slot(1'b0, 32'h1111_0000, 16, -1);
        tick(2);
        tests_run++; if (frame_err !== 1'b1) begin tests_failed++; $display("FAIL short_frame_err: got %b exp 1", frame_err); end
        tests_run++; if (got_q.size() != 0) begin tests_failed++; $display("FAIL short_no_pair: got %0d exp 0", got_q.size()); end
        tests_run++; if (dbg_state !== SEEK) begin tests_failed++; $display("FAIL short_state: got %0d exp %0d", dbg_state, SEEK); end
        send_frame(16'h7FFF, 16'h8000);
        tick(4);
        tests_run++; if (got_q.size() != 1) begin tests_failed++; $display("FAIL short_next_count: got %0d exp 1", got_q.size()); end
        else begin
            tests_run++; if (got_q[0] !== 32'h7FFF_8000) begin tests_failed++; $display("FAIL short_next_pair: got %h exp 7fff8000", got_q[0]); end
        end
        pulse_clear();
        tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL short_clear: got %b exp 0", frame_err); end
    endtask

    task automatic test_reset_mid_right();
        sample_ready = 1'b1;
        got_q.delete();
        send_slot(1'b1, 32'h9876_0000, 8, -1);
        reset_n = 1'b0;
        send_slot(1'b1, 32'h7600_0000, 8, -1);
        send_slot(1'b0, 32'hABCD_0000, 6, -1);
        reset_n = 1'b1;
        send_slot(1'b0, 32'hABCD_0000 << 6, 10, -1);
        tick(2);
        tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_frame_err: got %b exp 0", frame_err); end
        tests_run++; if (got_q.size() != 0) begin tests_failed++; $display("FAIL rst_mid_no_pair: got %0d exp 0", got_q.size()); end
        send_frame(16'h00AA, 16'h5500);
        tick(4);
        tests_run++; if (got_q.size() != 1) begin tests_failed++; $display("FAIL rst_mid_count: got %0d exp 1", got_q.size()); end
        else begin
            tests_run++; if (got_q[0] !== 32'h00AA_5500) begin tests_failed++; $display("FAIL rst_mid_pair: got %h exp 00aa5500", got_q[0]); end
        end
        tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_frame_err2: got %b exp 0", frame_err); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rA, lB, rB, lC, rC;
        rA = $urandom; lB = $urandom; rB = $urandom; lC = $urandom; rC = $urandom;
        sample_ready = 1'b0;
        got_q.delete(); exp_q.delete();
        exp_q.push_back({16'hCAFE, rA[31:16]});
        exp_q.push_back({lB[31:16], rB[31:16]});
        exp_q.push_back({lC[31:16], rC[31:16]});
        send_slot(1'b1, 32'hCAFE_0001, 32, -1);
        send_slot(1'b0, rA, 32, -1);
        tick(2);
        tests_run++; if (left_out !== 16'hCAFE) begin tests_failed++; $display("FAIL b2b_left_a: got %h exp cafe", left_out); end
        tests_run++; if (sample_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_held_a: got %b exp 1", sample_valid); end
        send_slot(1'b1, lB, 32, -1);
        send_slot(1'b0, rB, 16, 15);
        tests_run++; if (b2b_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid_kept: got %b exp 1", b2b_valid); end
        tests_run++; if (b2b_left !== lB[31:16]) begin tests_failed++; $display("FAIL b2b_left_b: got %h exp %h", b2b_left, lB[31:16]); end
        tests_run++; if (b2b_overrun !== 1'b0) begin tests_failed++; $display("FAIL b2b_overrun: got %b exp 0", b2b_overrun); end
        send_slot(1'b0, rB << 16, 16, -1);
        send_slot(1'b1, lC, 32, -1);
        send_slot(1'b0, rC, 32, -1);
        tick(4);
        tests_run++; if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL b2b_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL b2b_pair%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        tests_run++; if ({overrun, frame_err} !== 2'b00) begin tests_failed++; $display("FAIL b2b_flags: got %b exp 00", {overrun, frame_err}); end
    endtask

    task automatic test_enable();
        sample_ready = 1'b1;
        got_q.delete();
        enable = 1'b0;
        send_frame(16'h1357, 16'h2468);
        tick(2);
        tests_run++; if (got_q.size() != 0) begin tests_failed++; $display("FAIL en_off_no_pair: got %0d exp 0", got_q.size()); end
        tests_run++; if (dbg_state !== SEEK) begin tests_failed++; $display("FAIL en_off_state: got %0d exp %0d", dbg_state, SEEK); end
        enable = 1'b1;
        send_frame(16'h0F0F, 16'hF0F0);
        tick(4);
        tests_run++; if (got_q.size() != 1) begin tests_failed++; $display("FAIL en_on_count: got %0d exp 1", got_q.size()); end
        else begin
            tests_run++; if (got_q[0] !== 32'h0F0F_F0F0) begin tests_failed++; $display("FAIL en_on_pair: got %h exp 0f0ff0f0", got_q[0]); end
        end
    endtask

    task automatic test_reset_valid();
        logic [15:0] l, r;
        sample_ready = 1'b0;
        send_frame(16'h4444, 16'h5555);
        send_frame(16'h6666, 16'h7777);
        tick(2);
        tests_run++; if ({sample_valid, overrun} !== 2'b11) begin tests_failed++; $display("FAIL rstv_pre: got %b exp 11", {sample_valid, overrun}); end
        send_slot(1'b1, 32'hFFFF_0000, 7, -1);
        reset_n = 1'b0;
        #1;
        tests_run++; if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL rstv_valid: got %b exp 0", sample_valid); end
        tests_run++; if ({left_out, right_out} !== 32'h0) begin tests_failed++; $display("FAIL rstv_data: got %h exp 00000000", {left_out, right_out}); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL rstv_overrun: got %b exp 0", overrun); end
        tests_run++; if (dbg_state !== SEEK) begin tests_failed++; $display("FAIL rstv_state: got %0d exp %0d", dbg_state, SEEK); end
        aud_adclrck = 1'b0; aud_bclk = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(4);
        sample_ready = 1'b1;
        got_q.delete();
        l = 16'($urandom); r = 16'($urandom);
        send_frame(l, r);
        tick(4);
        tests_run++; if (got_q.size() != 1) begin tests_failed++; $display("FAIL rstv_next_count: got %0d exp 1", got_q.size()); end
        else begin
            tests_run++; if (got_q[0] !== {l, r}) begin tests_failed++; $display("FAIL rstv_next_pair: got %h exp %h", got_q[0], {l, r}); end
        end
    endtask

    // Random slot lengths: a frame yields a pair only when both slots carry at least
    // DATA_W bits; any short slot raises frame_err. A good trailing frame flushes a
    // short final right slot into the error flag.
    task automatic test_random();
        logic [31:0] l, r;
        int len_l, len_r;
        logic exp_err;
        sample_ready = 1'b1;
        pulse_clear();
        got_q.delete(); exp_q.delete();
        exp_err = 1'b0;
        for (int f = 0; f < 8; f++) begin
            l = $urandom; r = $urandom;
            len_l = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 15) : $urandom_range(16, 24);
            len_r = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 15) : $urandom_range(16, 24);
            send_slot(1'b1, l, len_l, -1);
            send_slot(1'b0, r, len_r, -1);
            if (len_l >= DATA_W && len_r >= DATA_W) exp_q.push_back({l[31:16], r[31:16]});
            else exp_err = 1'b1;
        end
        l = $urandom; r = $urandom;
        send_slot(1'b1, l, 16, -1);
        send_slot(1'b0, r, 16, -1);
        exp_q.push_back({l[31:16], r[31:16]});
        tick(4);
        tests_run++; if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL rand_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL rand_pair%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        tests_run++; if (frame_err !== exp_err) begin tests_failed++; $display("FAIL rand_frame_err: got %b exp %b", frame_err, exp_err); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL rand_overrun: got %b exp 0", overrun); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_short_left();
        test_reset_mid_right();
        test_back_to_back();
        test_enable();
        test_reset_valid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
